sqrt_rr_scheduler: RTL and testbench
====================================

Name: sqrt_rr_scheduler

Overview:
- Shares one instance of the existing combinational SquareRoot unit (16-bit operand a, 16-bit root b) among N_REQ requesters.
- Round-robin arbitration admits one operand at a time.
- The operand is registered in front of SquareRoot, held for a programmable settle window, and the root is captured into a result register.
- Result is returned on a single valid/ready response channel tagged with the requester index.
- Sits between client blocks needing integer square roots and the shared SquareRoot datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 16, operand/root width; must match SquareRoot.
- CALC_CYCLES, 1, cycles the registered operand is held at SquareRoot before capture (1..15); multicycle-path budget.
- IDW, 2, requester-index width, $clog2(N_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  N_REQ*DW  packed operands; requester i at [i*DW +: DW].
- req_ready  out  N_REQ  one-hot grant; at most one bit high.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  index of requester that issued the operand.
- resp_operand  out  DW  echoed operand.
- resp_root  out  DW  floor(sqrt(operand)); upper DW/2 bits always 0.
- busy  out  1  high in CALC or RESP.

Behaviour:
- Reset (async, immediate on rst rising): state=IDLE, ptr=0, cnt=0, a_q=0, id_q=0, root_q=0. Outputs: req_ready=0, resp_valid=0, resp_id=0, resp_operand=0, resp_root=0, busy=0.

FSM states:
- IDLE:
  - Winner = first i with req_valid[i] set, scanning ptr, ptr+1, ... mod N_REQ.
  - req_ready[winner]=1, combinational; all others 0. No valid request means req_ready=0.
  - On the edge with req_valid[w] & req_ready[w]: a_q<=req_data[w], id_q<=w, cnt<=0, ptr<=(w+1) mod N_REQ, state<=CALC.
- CALC:
  - SquareRoot input driven only from a_q.
  - cnt increments each cycle.
  - When cnt==CALC_CYCLES-1: root_q<=b, state<=RESP.
  - req_ready=0.
- RESP:
  - resp_valid=1; resp_id=id_q, resp_operand=a_q, resp_root=root_q.
  - All response outputs are stable while resp_ready=0.
  - On resp_valid & resp_ready: state<=IDLE.
  - req_ready=0, so no overlap.

Timing and throughput:
- Latency: request accepted at edge E; resp_valid rises after edge E+CALC_CYCLES.
- Minimum spacing between acceptances is CALC_CYCLES+2 cycles.

Rules and boundary conditions:
- Requesters must hold req_valid/req_data until granted. Dropping req_valid before grant is legal; the request is simply not served.
- ptr advances only on acceptance. Idle cycles do not rotate it.
- A single requester held continuously is served back-to-back. With two active requesters, service strictly alternates.
- Operand 0 gives root 0. Operand 2^DW-1 gives 2^(DW/2)-1 (255 at DW=16).
- Reset in CALC or RESP: the pending result is discarded, with no response emitted.
- resp_ready high while not in RESP is ignored.
- Changes on req_data after acceptance do not affect the in-flight result.

Decomposition:
- Shared package sqrt_sched_pkg:
  - state enum {IDLE, CALC, RESP}.
  - Localparams for the default DW and N_REQ.
  - Function rr_pick(valid, ptr) returning the winner index and a found flag.
- One natural sub-module: rr_arbiter (combinational round-robin pick plus registered ptr, advance-on-accept input), reusable by other shared-datapath schedulers.
- SquareRoot is instantiated as-is and is not modified.

Test Plan:
1. Single request: req_valid=4'b0001, req_data[0]=16 -> accepted in IDLE; at CALC_CYCLES=1 resp_valid rises 2 edges later with id=0, operand=16, root=4; busy high throughout.
2. All four requesters valid together with operands 16, 9, 1, 3 and resp_ready=1 -> responses in order id 0,1,2,3 with roots 4,3,1,1; each acceptance spaced 3 cycles.
3. Fairness: req 0 and req 2 held continuously (operands 49 and 100) -> ids alternate 0,2,0,2 with roots 7,10; req_ready never has 2 bits set.
4. Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_* stable, req_ready=0 despite pending requests; resp_ready=1 -> handshake, then next grant in the following cycle.
5. Boundaries: operand 0 -> root 0; operand 65535 -> root 255; operand 65025 -> 255; operand 65024 -> 254; upper 8 root bits always 0.
6. Reset mid-CALC with CALC_CYCLES=4 -> outputs go to 0 immediately, no resp_valid; after release, a new request for 9 returns root 3 with id per ptr=0.

Source files
------------

// File: rtl/sqrt_sched_pkg.sv
// Shared types and the round-robin pick function for schedulers that
// time-share a single square-root datapath.
package sqrt_sched_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_N_REQ = 4;
  localparam int MAX_N_REQ = 8;
  localparam int PICK_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr, ptr+1, ... (mod n) and return the first requester with valid set.
  function automatic rr_pick_t rr_pick(input logic [MAX_N_REQ-1:0] valid,
                                       input logic [PICK_W-1:0]    ptr,
                                       input int                   n);
    rr_pick_t pick_s;
    int       j;
    pick_s.found = 1'b0;
    pick_s.idx   = 3'd0;
    for (int k = 0; k < MAX_N_REQ; k++) begin
      j = (int'(ptr) + k) % n;
      if ((k < n) && !pick_s.found && valid[j[PICK_W-1:0]]) begin
        pick_s.found = 1'b1;
        pick_s.idx   = j[PICK_W-1:0];
      end
    end
    return pick_s;
  endfunction

endpackage

// File: rtl/SquareRoot.sv
// Combinational integer square root: b = floor(sqrt(a)), upper byte always 0.
module SquareRoot (
  input  logic [15:0] a,
  output logic [15:0] b
);

  logic [7:0]  root_s;
  logic [7:0]  cand_s;
  logic [15:0] sq_s;

  // Greedy bit-by-bit root: keep each bit whose square still fits under a.
  always_comb begin
    root_s = 8'd0;
    cand_s = 8'd0;
    sq_s   = 16'd0;
    for (int i = 7; i >= 0; i--) begin
      cand_s = root_s | (8'd1 << i);
      sq_s   = {8'd0, cand_s} * {8'd0, cand_s};
      if (sq_s <= a) begin
        root_s = cand_s;
      end else begin
        root_s = root_s;
      end
    end
    b = {8'd0, root_s};
  end

endmodule

// File: rtl/sqrt_rr_scheduler_arbiter.sv
// Round-robin arbiter: combinational pick from a registered pointer that
// advances past the winner only when the grant is actually taken.
module rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid,
  input  logic             enable,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             found
);

  logic [IDW-1:0]       ptr_r;
  logic [IDW-1:0]       next_ptr_s;
  logic [MAX_N_REQ-1:0] valid_ext_s;
  rr_pick_t             pick_s;

  // Winner search starting at the rotating pointer.
  always_comb begin
    valid_ext_s              = 8'd0;
    valid_ext_s[N_REQ-1:0]   = valid;
    pick_s                   = rr_pick(valid_ext_s, PICK_W'(ptr_r), N_REQ);
    grant_idx                = pick_s.idx[IDW-1:0];
    found                    = pick_s.found;
  end

  // One-hot grant, suppressed whenever the consumer cannot take an operand.
  always_comb begin
    grant = {N_REQ{1'b0}};
    if (enable && pick_s.found) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = {N_REQ{1'b0}};
    end
  end

  // Pointer moves to the requester after the winner, wrapping at N_REQ.
  always_comb begin
    if (grant_idx == IDW'(N_REQ - 1)) begin
      next_ptr_s = {IDW{1'b0}};
    end else begin
      next_ptr_s = grant_idx + 1'b1;
    end
  end

  // Idle cycles leave the pointer untouched so fairness follows service order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {IDW{1'b0}};
    end else if (accept) begin
      ptr_r <= next_ptr_s;
    end
  end

endmodule

// File: rtl/sqrt_rr_scheduler.sv
// Time-shares one SquareRoot unit among N_REQ requesters: round-robin admit,
// hold the operand for CALC_CYCLES, then return a tagged result.
module sqrt_rr_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DW          = DEF_DW,
  parameter int CALC_CYCLES = 1,
  parameter int IDW         = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [DW-1:0]       resp_operand,
  output logic [DW-1:0]       resp_root,
  output logic                busy
);

  state_e         state_r;
  state_e         state_nxt_s;
  logic [3:0]     cnt_r;
  logic [DW-1:0]  a_r;
  logic [DW-1:0]  root_r;
  logic [IDW-1:0] id_r;
  logic [DW-1:0]  sqrt_b_s;
  logic [DW-1:0]  sel_data_s;
  logic [IDW-1:0] grant_idx_s;
  logic           found_s;
  logic           arb_en_s;
  logic           accept_s;
  logic           calc_done_s;

  assign arb_en_s    = (state_r == IDLE) && !rst;
  assign accept_s    = arb_en_s && found_s;
  assign calc_done_s = (cnt_r == 4'(CALC_CYCLES - 1));
  assign sel_data_s  = req_data[int'(grant_idx_s) * DW +: DW];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .enable    (arb_en_s),
    .accept    (accept_s),
    .grant     (req_ready),
    .grant_idx (grant_idx_s),
    .found     (found_s)
  );

  // The datapath only ever sees the registered operand, making it a multicycle path.
  SquareRoot u_sqrt (
    .a (a_r),
    .b (sqrt_b_s)
  );

  // Next-state decode for the admit / compute / respond sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = CALC;
        else          state_nxt_s = IDLE;
      end
      CALC: begin
        if (calc_done_s) state_nxt_s = RESP;
        else             state_nxt_s = CALC;
      end
      RESP: begin
        if (resp_ready) state_nxt_s = IDLE;
        else            state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, settle counter and root capture; later req_data changes cannot reach a_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= {DW{1'b0}};
      id_r   <= {IDW{1'b0}};
      cnt_r  <= 4'd0;
      root_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r   <= sel_data_s;
            id_r  <= grant_idx_s;
            cnt_r <= 4'd0;
          end
        end
        CALC: begin
          cnt_r <= cnt_r + 4'd1;
          if (calc_done_s) begin
            root_r <= sqrt_b_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign resp_valid   = (state_r == RESP);
  assign resp_id      = resp_valid ? id_r : {IDW{1'b0}};
  assign resp_operand = resp_valid ? a_r : {DW{1'b0}};
  assign resp_root    = resp_valid ? root_r : {DW{1'b0}};
  assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Directed bench for sqrt_rr_scheduler: one instance with a 1-cycle settle
// window and one with a 4-cycle window for the mid-compute reset case.
module tb_sqrt_rr_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [15:0] resp_operand;
  logic [15:0] resp_root;
  logic        busy;

  logic        rst4;
  logic [3:0]  req_valid4;
  logic [63:0] req_data4;
  logic [3:0]  req_ready4;
  logic        resp_valid4;
  logic        resp_ready4;
  logic [1:0]  resp_id4;
  logic [15:0] resp_operand4;
  logic [15:0] resp_root4;
  logic        busy4;

  int checks = 0;
  int errors = 0;

  sqrt_rr_scheduler #(.N_REQ(4), .DW(16), .CALC_CYCLES(1), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_operand(resp_operand), .resp_root(resp_root),
    .busy(busy)
  );

  sqrt_rr_scheduler #(.N_REQ(4), .DW(16), .CALC_CYCLES(4), .IDW(2)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_data(req_data4),
    .req_ready(req_ready4), .resp_valid(resp_valid4), .resp_ready(resp_ready4),
    .resp_id(resp_id4), .resp_operand(resp_operand4), .resp_root(resp_root4),
    .busy(busy4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rst4 = 1'b0;
    req_valid = 4'b0000; req_data = 64'd0; resp_ready = 1'b0;
    req_valid4 = 4'b0000; req_data4 = 64'd0; resp_ready4 = 1'b0;
    #2;
    rst = 1'b1; rst4 = 1'b1;
    req_valid = 4'b1111;
    #2;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0000); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if ({resp_id, resp_operand, resp_root} !== 34'd0) begin errors++; $display("FAIL reset_resp_fields: got id=%0d op=%0d root=%0d expected 0", resp_id, resp_operand, resp_root); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (busy4 !== 1'b0 || resp_valid4 !== 1'b0) begin errors++; $display("FAIL reset_dut4: got busy=%b valid=%b expected 0", busy4, resp_valid4); end
    step(); step();
    req_valid = 4'b0000;
    rst = 1'b0; rst4 = 1'b0;
  endtask

  task automatic test_single();
    req_data[15:0] = 16'd16;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected %b", req_ready, 4'b0001); end
    step();
    req_valid = 4'b0000;
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL single_calc: got busy=%b valid=%b ready=%b expected 1 0 0000", busy, resp_valid, req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_valid: got valid=%b busy=%b expected 1 1", resp_valid, busy); end
    checks++; if (resp_id !== 2'd0 || resp_operand !== 16'd16 || resp_root !== 16'd4) begin errors++; $display("FAIL single_resp: got id=%0d op=%0d root=%0d expected 0 16 4", resp_id, resp_operand, resp_root); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got valid=%b busy=%b expected 0 0", resp_valid, busy); end
  endtask

  task automatic test_all4();
    logic [15:0] exp_root [0:3];
    exp_root[0] = 16'd4; exp_root[1] = 16'd3; exp_root[2] = 16'd1; exp_root[3] = 16'd1;
    apply_reset();
    req_data = {16'd3, 16'd1, 16'd9, 16'd16};
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << k)) begin errors++; $display("FAIL all4_grant%0d: got %b expected %b", k, req_ready, 4'b0001 << k); end
      step();
      req_valid[k] = 1'b0;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL all4_calc%0d: got valid=%b expected 0", k, resp_valid); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(k) || resp_root !== exp_root[k]) begin errors++; $display("FAIL all4_resp%0d: got valid=%b id=%0d root=%0d expected 1 %0d %0d", k, resp_valid, resp_id, resp_root, k, exp_root[k]); end
      step();
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_id;
    logic [15:0] exp_root;
    req_data[15:0]  = 16'd49;
    req_data[47:32] = 16'd100;
    req_valid = 4'b0101;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id   = (k % 2 == 0) ? 2'd0 : 2'd2;
      exp_root = (k % 2 == 0) ? 16'd7 : 16'd10;
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_id)) begin errors++; $display("FAIL fair_grant%0d: got %b expected %b", k, req_ready, 4'b0001 << exp_id); end
      step();
      checks++; if ($countones(req_ready) > 1) begin errors++; $display("FAIL fair_onehot%0d: got %b expected at most one bit", k, req_ready); end
      step();
      checks++; if (resp_id !== exp_id || resp_root !== exp_root) begin errors++; $display("FAIL fair_resp%0d: got id=%0d root=%0d expected %0d %0d", k, resp_id, resp_root, exp_id, exp_root); end
      step();
    end
    req_valid = 4'b0000;
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    req_data[31:16] = 16'd25;
    req_data[63:48] = 16'd64;
    req_valid = 4'b1010;
    resp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant3: got %b expected %b", req_ready, 4'b1000); end
    step();
    req_data[63:48] = 16'd1234;
    step();
    for (int k = 0; k < 10; k++) begin
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_operand !== 16'd64 || resp_root !== 16'd8 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold%0d: got valid=%b id=%0d op=%0d root=%0d ready=%b expected 1 3 64 8 0000", k, resp_valid, resp_id, resp_operand, resp_root, req_ready); end
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant: got valid=%b ready=%b expected 0 0010", resp_valid, req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    checks++; if (resp_id !== 2'd1 || resp_operand !== 16'd25 || resp_root !== 16'd5) begin errors++; $display("FAIL bp_resp1: got id=%0d op=%0d root=%0d expected 1 25 5", resp_id, resp_operand, resp_root); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [15:0] ops   [0:3];
    logic [15:0] roots [0:3];
    ops[0] = 16'd0;     roots[0] = 16'd0;
    ops[1] = 16'd65535; roots[1] = 16'd255;
    ops[2] = 16'd65025; roots[2] = 16'd255;
    ops[3] = 16'd65024; roots[3] = 16'd254;
    req_valid = 4'b0001;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_data[15:0] = ops[k];
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bnd_grant%0d: got %b expected 0001", k, req_ready); end
      step();
      step();
      checks++; if (resp_valid !== 1'b1 || resp_operand !== ops[k] || resp_root !== roots[k]) begin errors++; $display("FAIL bnd_root%0d: got valid=%b op=%0d root=%0d expected 1 %0d %0d", k, resp_valid, resp_operand, resp_root, ops[k], roots[k]); end
      checks++; if (resp_root[15:8] !== 8'd0) begin errors++; $display("FAIL bnd_upper%0d: got %h expected 00", k, resp_root[15:8]); end
      step();
    end
    req_valid = 4'b0000;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    req_data4[47:32] = 16'd200;
    req_valid4 = 4'b0100;
    resp_ready4 = 1'b1;
    #1;
    checks++; if (req_ready4 !== 4'b0100) begin errors++; $display("FAIL rst4_grant: got %b expected 0100", req_ready4); end
    step();
    step();
    checks++; if (busy4 !== 1'b1 || resp_valid4 !== 1'b0) begin errors++; $display("FAIL rst4_calc: got busy=%b valid=%b expected 1 0", busy4, resp_valid4); end
    rst4 = 1'b1;
    #1;
    checks++; if (busy4 !== 1'b0 || resp_valid4 !== 1'b0 || req_ready4 !== 4'b0000 || resp_root4 !== 16'd0) begin errors++; $display("FAIL rst4_immediate: got busy=%b valid=%b ready=%b root=%0d expected 0 0 0000 0", busy4, resp_valid4, req_ready4, resp_root4); end
    step();
    step();
    checks++; if (resp_valid4 !== 1'b0) begin errors++; $display("FAIL rst4_held: got valid=%b expected 0", resp_valid4); end
    rst4 = 1'b0;
    req_data4 = {16'd9, 16'd9, 16'd9, 16'd9};
    req_valid4 = 4'b1111;
    #1;
    checks++; if (req_ready4 !== 4'b0001) begin errors++; $display("FAIL rst4_ptr0: got %b expected 0001", req_ready4); end
    step();
    req_valid4 = 4'b0000;
    for (int j = 0; j < 3; j++) begin
      step();
      checks++; if (resp_valid4 !== 1'b0) begin errors++; $display("FAIL rst4_latency%0d: got valid=%b expected 0", j, resp_valid4); end
    end
    step();
    checks++; if (resp_valid4 !== 1'b1 || resp_id4 !== 2'd0 || resp_operand4 !== 16'd9 || resp_root4 !== 16'd3) begin errors++; $display("FAIL rst4_resp: got valid=%b id=%0d op=%0d root=%0d expected 1 0 9 3", resp_valid4, resp_id4, resp_operand4, resp_root4); end
    step();
    checks++; if (resp_valid4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL rst4_done: got valid=%b busy=%b expected 0 0", resp_valid4, busy4); end
    resp_ready4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_fairness();
    test_backpressure();
    test_boundaries();
    test_reset_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
